ps2_key_decoder: RTL and testbench

Parametrised PS/2 keyboard command decoder that sits between `PS2_Controller` (raw byte stream) and the game control FSM. It parses set-2 make, break and extended (E0) sequences and tracks held state per mapped key. It emits one pulse per physical press, suppressing typematic repeats, and queues press events in a small FIFO so the consumer can take them at its own pace.

---
 rtl/ps2_key_decoder_pkg.sv | 25 ++
 rtl/ps2_key_decoder_if.sv | 12 +
 rtl/ps2_key_decoder_evt_fifo.sv | 77 +++++++
 rtl/ps2_key_decoder.sv | 166 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 set-2 definitions: prefix bytes, blackjack key scan codes and
// the parser state encoding used by the keyboard decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] SC_HIT   = 8'h33;
    localparam logic [7:0] SC_STAND = 8'h1B;
    localparam logic [7:0] SC_DEAL  = 8'h23;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event bus between the decoder (master) and the game FSM (slave):
// valid/ready handshake carrying the index of a freshly pressed key.
interface ps2_key_decoder_if #(
    parameter int IDX_W = 2
) ();
    logic             evt_valid;
    logic [IDX_W-1:0] evt_id;
    logic             evt_ready;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/ps2_key_decoder_evt_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count and a sticky
// overflow flag for pushes refused while full.
module ps2_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop_ok_s, push_ok_s;

    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        pop_ok_s   = pop && (count_q != (AW + 1)'(0));
        push_ok_s  = push && ((count_q != FULL_CNT) || pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            overflow_d = overflow_q | push;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == (AW + 1)'(0));
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: parses make/break/E0 sequences, tracks held keys,
// pulses once per fresh press and queues press events for the game FSM.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {SC_ENTER, SC_DEAL, SC_STAND, SC_HIT},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1000,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT_CYCLES = 100_000,
    localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [NUM_KEYS-1:0]  key_pulse,
    output logic [NUM_KEYS-1:0]  key_held,
    ps2_key_decoder_if.master    evt,
    output logic                 evt_overflow,
    output logic [7:0]           last_code,
    output logic                 last_ext
);
    localparam int               TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam int               FAW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    ps2_state_e          state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_KEYS-1:0] key_pulse_q, key_pulse_d, key_held_q, key_held_d;
    logic [7:0]          last_code_q, last_code_d;
    logic                last_ext_q, last_ext_d;
    logic                make_s, brk_s, ext_s, hit_s, push_s;
    logic [NUM_KEYS-1:0] match_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic                fifo_empty_s, fifo_full_s;
    logic [FAW:0]        fifo_count_s;
    logic                unused_fifo_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Parser next state and timeout; a byte in the expiry cycle wins over expiry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        make_s  = 1'b0;
        brk_s   = 1'b0;
        ext_s   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        if (rx_valid) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == PS2_EXT)        state_d = ST_EXT;
                    else if (rx_data == PS2_BRK)   state_d = ST_BRK;
                    else if (rx_data == PS2_PAUSE) state_d = ST_IDLE;
                    else                           make_s  = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == PS2_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_data == PS2_EXT) state_d = ST_EXT;
                    else begin
                        make_s  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    brk_s   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TMR_MAX) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Key map lookup on the current byte and its extension flag.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match_s[i] = (rx_data == KEY_CODES[8*i +: 8]) && (ext_s == KEY_EXT[i]);
        end
        hit_s     = |match_s;
        hit_idx_s = lowest_set(match_s);
    end

    // Held tracking, typematic suppression, event push and debug capture.
    always_comb begin
        key_pulse_d = '0;
        key_held_d  = key_held_q;
        push_s      = 1'b0;
        last_code_d = last_code_q;
        last_ext_d  = last_ext_q;
        if ((make_s || brk_s) && !is_prefix(rx_data)) begin
            last_code_d = rx_data;
            last_ext_d  = ext_s;
        end else begin
            last_code_d = last_code_q;
        end
        if (make_s && hit_s && !key_held_q[hit_idx_s]) begin
            key_pulse_d[hit_idx_s] = 1'b1;
            key_held_d[hit_idx_s]  = 1'b1;
            push_s                 = 1'b1;
        end else if (brk_s && hit_s) begin
            key_held_d[hit_idx_s] = 1'b0;
        end else begin
            key_held_d = key_held_q;
        end
    end

    // Parser and key state registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            key_pulse_q <= '0;
            key_held_q  <= '0;
            last_code_q <= 8'h00;
            last_ext_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            key_pulse_q <= key_pulse_d;
            key_held_q  <= key_held_d;
            last_code_q <= last_code_d;
            last_ext_q  <= last_ext_d;
        end
    end

    ps2_evt_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .push      (push_s),
        .push_data (hit_idx_s),
        .pop       (evt.evt_ready),
        .pop_data  (evt.evt_id),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s),
        .overflow  (evt_overflow)
    );

    assign unused_fifo_s = ^{fifo_full_s, fifo_count_s};
    assign evt.evt_valid = ~fifo_empty_s;
    assign key_pulse     = key_pulse_q;
    assign key_held      = key_held_q;
    assign last_code     = last_code_q;
    assign last_ext      = last_ext_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus queues expected pulses and
// events; a monitor pops and compares whenever the DUT presents them.
module tb_ps2_key_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] key_pulse, key_held;
    logic       evt_overflow;
    logic [7:0] last_code;
    logic       last_ext;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_pulse_q [$];
    logic [1:0] exp_evt_q   [$];

    ps2_key_decoder_if #(.IDX_W(2)) evt_if ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .key_pulse    (key_pulse),
        .key_held     (key_held),
        .evt          (evt_if),
        .evt_overflow (evt_overflow),
        .last_code    (last_code),
        .last_ext     (last_ext)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
    endtask

    // Bytes sent on consecutive cycles, most significant byte first.
    task automatic send_b2b(input logic [23:0] seq, input int n);
        @(negedge CLOCK_50);
        for (int i = 0; i < n; i++) begin
            rx_data  = seq[8*(n-1-i) +: 8];
            rx_valid = 1'b1;
            @(negedge CLOCK_50);
        end
        rx_valid = 1'b0;
    endtask

    task automatic expect_press(input logic [3:0] pulse, input logic [1:0] id, input bit queued);
        exp_pulse_q.push_back(pulse);
        if (queued) exp_evt_q.push_back(id);
    endtask

    // Monitor: compares every pulse and every accepted event against the queues.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            #1;
            if (!reset) begin
                if (key_pulse !== 4'b0000) begin
                    if (exp_pulse_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pulse_unexpected: actual=%0h expected=none", key_pulse);
                    end else begin
                        check("pulse", 32'(key_pulse), 32'(exp_pulse_q.pop_front()));
                    end
                end
                if (evt_if.evt_valid && evt_if.evt_ready) begin
                    if (exp_evt_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL evt_unexpected: actual=%0h expected=none", evt_if.evt_id);
                    end else begin
                        check("evt_id", 32'(evt_if.evt_id), 32'(exp_evt_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        evt_if.evt_ready = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_held", 32'(key_held), 32'h0);
        check("rst_pulse", 32'(key_pulse), 32'h0);
        check("rst_evt_valid", 32'(evt_if.evt_valid), 32'h0);
        check("rst_evt_id", 32'(evt_if.evt_id), 32'h0);
        check("rst_overflow", 32'(evt_overflow), 32'h0);
        check("rst_last_code", 32'(last_code), 32'h0);
        check("rst_last_ext", 32'(last_ext), 32'h0);
        reset = 1'b0;
        evt_if.evt_ready = 1'b1;

        // H press then release
        expect_press(4'b0001, 2'd0, 1'b1);
        send(8'h33);
        check("h_held", 32'(key_held), 32'h1);
        check("h_evt_valid", 32'(evt_if.evt_valid), 32'h1);
        check("h_evt_id", 32'(evt_if.evt_id), 32'h0);
        send_b2b(24'h00F033, 2);
        check("h_release", 32'(key_held), 32'h0);

        // Typematic repeats give one press only
        expect_press(4'b0001, 2'd0, 1'b1);
        send_b2b(24'h333333, 3);
        check("typ_held", 32'(key_held), 32'h1);
        check("typ_last_code", 32'(last_code), 32'h33);
        send_b2b(24'h00F033, 2);

        // Extended Enter vs plain 5A
        expect_press(4'b1000, 2'd3, 1'b1);
        send_b2b(24'h00E05A, 2);
        check("ext_held", 32'(key_held), 32'h8);
        check("ext_last_code", 32'(last_code), 32'h5A);
        check("ext_last_ext", 32'(last_ext), 32'h1);
        send(8'h5A);
        check("plain_last_code", 32'(last_code), 32'h5A);
        check("plain_last_ext", 32'(last_ext), 32'h0);
        check("plain_held", 32'(key_held), 32'h8);
        send_b2b(24'hE0F05A, 3);
        check("ext_release", 32'(key_held), 32'h0);
        check("ext_brk_last_ext", 32'(last_ext), 32'h1);

        // Timeouts
        send(8'hE0);
        repeat (80) @(negedge CLOCK_50);
        send(8'h5A);
        check("tmo_ext_last_ext", 32'(last_ext), 32'h0);
        check("tmo_ext_held", 32'(key_held), 32'h0);
        send(8'hE0);
        repeat (40) @(negedge CLOCK_50);
        expect_press(4'b1000, 2'd3, 1'b1);
        send(8'h5A);
        check("no_tmo_held", 32'(key_held), 32'h8);
        send_b2b(24'hE0F05A, 3);
        send(8'hF0);
        repeat (80) @(negedge CLOCK_50);
        expect_press(4'b0001, 2'd0, 1'b1);
        send(8'h33);
        check("tmo_brk_make", 32'(key_held), 32'h1);
        send_b2b(24'h00F033, 2);
        check("tmo_brk_release", 32'(key_held), 32'h0);

        // FIFO fill with five presses, consumer stalled
        repeat (4) @(negedge CLOCK_50);
        check("fifo_pre_empty", 32'(evt_if.evt_valid), 32'h0);
        evt_if.evt_ready = 1'b0;
        expect_press(4'b0001, 2'd0, 1'b1);
        send(8'h33);
        send_b2b(24'h00F033, 2);
        expect_press(4'b0010, 2'd1, 1'b1);
        send(8'h1B);
        send_b2b(24'h00F01B, 2);
        expect_press(4'b0100, 2'd2, 1'b1);
        send(8'h23);
        send_b2b(24'h00F023, 2);
        expect_press(4'b1000, 2'd3, 1'b1);
        send_b2b(24'h00E05A, 2);
        send_b2b(24'hE0F05A, 3);
        check("fifo_no_ovf_yet", 32'(evt_overflow), 32'h0);
        expect_press(4'b0001, 2'd0, 1'b0);
        send(8'h33);
        check("fifo_overflow", 32'(evt_overflow), 32'h1);
        check("fifo_valid", 32'(evt_if.evt_valid), 32'h1);
        check("fifo_head", 32'(evt_if.evt_id), 32'h0);
        evt_if.evt_ready = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        check("fifo_drained", 32'(evt_if.evt_valid), 32'h0);
        check("fifo_drain_count", 32'(exp_evt_q.size()), 32'h0);
        check("fifo_ovf_sticky", 32'(evt_overflow), 32'h1);
        send_b2b(24'h00F033, 2);

        // Reset mid-sequence with events queued
        evt_if.evt_ready = 1'b0;
        expect_press(4'b0001, 2'd0, 1'b0);
        send(8'h33);
        expect_press(4'b0010, 2'd1, 1'b0);
        send(8'h1B);
        send(8'hE0);
        check("pre_rst_valid", 32'(evt_if.evt_valid), 32'h1);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("mid_rst_held", 32'(key_held), 32'h0);
        check("mid_rst_valid", 32'(evt_if.evt_valid), 32'h0);
        check("mid_rst_evt_id", 32'(evt_if.evt_id), 32'h0);
        check("mid_rst_overflow", 32'(evt_overflow), 32'h0);
        check("mid_rst_last_code", 32'(last_code), 32'h0);
        evt_if.evt_ready = 1'b1;
        expect_press(4'b0001, 2'd0, 1'b1);
        send(8'h33);
        check("post_rst_held", 32'(key_held), 32'h1);
        check("post_rst_last_ext", 32'(last_ext), 32'h0);

        repeat (5) @(negedge CLOCK_50);
        check("pulse_queue_empty", 32'(exp_pulse_q.size()), 32'h0);
        check("evt_queue_empty", 32'(exp_evt_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
